// File: rtl/pass_sequencer.sv
// rtl/pass_sequencer.sv - forward/backward pass controller with watchdog, abort and sequence counter
//
// Steps the layer datapath through NUM_FWD forward passes and an optional
// backward pass. Each pass ends on a pass_end_i strobe from the datapath.
// A per-pass watchdog moves the controller to ERR if a pass overruns.
// All outputs are Moore decodes of the registered state.
//
// Ports:
//   clk_i       clock
//   rst_i       asynchronous active-low reset
//   en_i        global enable; when low, all state holds and all inputs are ignored
//   start_i     begins a sequence when sampled in IDLE
//   bwd_en_i    sampled with start_i; 1 appends a backward pass
//   pass_end_i  single-cycle strobe: the current pass is finished
//   abort_i     returns to IDLE from any non-IDLE state
//   fwd_pass_o  one-hot; bit k is high during forward pass k
//   b_pass_o    high during the backward pass
//   busy_o      high during any forward or backward pass
//   done_o      high in the DONE state
//   err_o       high in the ERR state
//   iter_o      number of sequences that reached DONE, modulo 2^ITER_W

module pass_sequencer #(
    parameter int NUM_FWD = 2,
    parameter int TIMEOUT = 255,
    parameter int ITER_W  = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               start_i,
    input  logic               bwd_en_i,
    input  logic               pass_end_i,
    input  logic               abort_i,
    output logic [NUM_FWD-1:0] fwd_pass_o,
    output logic               b_pass_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [ITER_W-1:0]  iter_o
);

    // A single forward pass still needs a 1-bit index register.
    localparam int IDX_W = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1;
    // TIMEOUT=0 would give a zero-width counter; keep one bit that stays at 0.
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FWD - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FWD  = 3'd1,
        S_BWD  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [WD_W-1:0]     wd_q,    wd_d;
    logic                bwd_q,   bwd_d;
    logic [ITER_W-1:0]   iter_q,  iter_d;

    logic                in_pass;
    logic                wd_expire;
    logic                stay_in_pass;

    assign in_pass      = (state_q == S_FWD) || (state_q == S_BWD);
    assign wd_expire    = (TIMEOUT != 0) && (wd_q == WD_LAST);
    // The pass continues this cycle only if neither higher-priority event fires.
    assign stay_in_pass = in_pass && !abort_i && !pass_end_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wd_q    <= '0;
            bwd_q   <= 1'b0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            bwd_q   <= bwd_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        bwd_d   = bwd_q;
        iter_d  = iter_q;

        if (en_i) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_FWD;
                        idx_d   = '0;
                        bwd_d   = bwd_en_i;
                    end
                end
                S_FWD: begin
                    if (abort_i) begin
                        state_d = S_IDLE;
                    end else if (pass_end_i) begin
                        if (idx_q != IDX_LAST) begin
                            idx_d = idx_q + 1'b1;
                        end else if (bwd_q) begin
                            state_d = S_BWD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else if (wd_expire) begin
                        state_d = S_ERR;
                    end
                end
                S_BWD: begin
                    if (abort_i) begin
                        state_d = S_IDLE;
                    end else if (pass_end_i) begin
                        state_d = S_DONE;
                    end else if (wd_expire) begin
                        state_d = S_ERR;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                S_ERR: begin
                    if (abort_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Any pass change (including FWD(k) -> FWD(k+1)) restarts the watchdog.
            if (!stay_in_pass || (TIMEOUT == 0)) begin
                wd_d = '0;
            end else if (wd_q != WD_MAX) begin
                wd_d = wd_q + 1'b1;
            end

            if ((state_d == S_DONE) && (state_q != S_DONE)) begin
                iter_d = iter_q + 1'b1;
            end
        end
    end

    always_comb begin
        fwd_pass_o = '0;
        for (int k = 0; k < NUM_FWD; k++) begin
            fwd_pass_o[k] = (state_q == S_FWD) && (idx_q == IDX_W'(k));
        end
    end

    assign b_pass_o = (state_q == S_BWD);
    assign busy_o   = in_pass;
    assign done_o   = (state_q == S_DONE);
    assign err_o    = (state_q == S_ERR);
    assign iter_o   = iter_q;

endmodule

// File: tb/tb_pass_sequencer.sv
// tb/tb_pass_sequencer.sv - self-checking bench for pass_sequencer

module tb_pass_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic       start_i;
    logic       bwd_en_i;
    logic       pass_end_i;
    logic       abort_i;
    logic [1:0] fwd_pass_o;
    logic       b_pass_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [7:0] iter_o;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_iter = 8'd0;
    logic [13:0] sb[$];

    pass_sequencer #(
        .NUM_FWD (2),
        .TIMEOUT (16),
        .ITER_W  (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .start_i    (start_i),
        .bwd_en_i   (bwd_en_i),
        .pass_end_i (pass_end_i),
        .abort_i    (abort_i),
        .fwd_pass_o (fwd_pass_o),
        .b_pass_o   (b_pass_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .iter_o     (iter_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [13:0] obs();
        return {fwd_pass_o, b_pass_o, busy_o, done_o, err_o, iter_o};
    endfunction

    function automatic logic [13:0] pk(input logic [1:0] fwd, input logic b,
                                       input logic d, input logic e);
        return {fwd, b, (fwd != 2'b00) || b, d, e, exp_iter};
    endfunction

    task automatic step(input logic en, input logic st, input logic bwd,
                        input logic pe, input logic ab);
        en_i       = en;
        start_i    = st;
        bwd_en_i   = bwd;
        pass_end_i = pe;
        abort_i    = ab;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] e, got;
        rst_i = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        sb.push_back(14'd0);
        got = obs();
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset got %h exp %h", got, e);
        end
        rst_i = 1'b1;
    endtask

    task automatic test_fwd_bwd();
        logic [13:0] e, got;
        for (int i = 0; i <= 17; i++) begin
            if (i < 5)       e = pk(2'b01, 1'b0, 1'b0, 1'b0);
            else if (i < 10) e = pk(2'b10, 1'b0, 1'b0, 1'b0);
            else if (i < 15) e = pk(2'b00, 1'b1, 1'b0, 1'b0);
            else if (i == 15) begin
                exp_iter = exp_iter + 8'd1;
                e = pk(2'b00, 1'b0, 1'b1, 1'b0);
            end else         e = pk(2'b00, 1'b0, 1'b0, 1'b0);
            sb.push_back(e);
            step(1'b1, (i == 0) || (i == 16), 1'b1, (i == 5) || (i == 10) || (i == 15), 1'b0);
            got = obs();
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL fwd_bwd step %0d got %h exp %h", i, got, e);
            end
        end
    endtask

    task automatic test_no_bwd();
        logic [13:0] e, got;
        for (int i = 0; i <= 11; i++) begin
            if (i < 5)       e = pk(2'b01, 1'b0, 1'b0, 1'b0);
            else if (i < 10) e = pk(2'b10, 1'b0, 1'b0, 1'b0);
            else if (i == 10) begin
                exp_iter = exp_iter + 8'd1;
                e = pk(2'b00, 1'b0, 1'b1, 1'b0);
            end else         e = pk(2'b00, 1'b0, 1'b0, 1'b0);
            sb.push_back(e);
            step(1'b1, i == 0, i != 0, (i == 5) || (i == 10), 1'b0);
            got = obs();
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL no_bwd step %0d got %h exp %h", i, got, e);
            end
        end
    endtask

    task automatic test_watchdog();
        logic [13:0] e, got;
        logic        busy_in;
        for (int i = 0; i <= 22; i++) begin
            busy_in = (i >= 18) && (i <= 20);
            if (i == 0)       e = pk(2'b01, 1'b0, 1'b0, 1'b0);
            else if (i <= 16) e = pk(2'b10, 1'b0, 1'b0, 1'b0);
            else if (i <= 20) e = pk(2'b00, 1'b0, 1'b0, 1'b1);
            else              e = pk(2'b00, 1'b0, 1'b0, 1'b0);
            sb.push_back(e);
            step(1'b1, (i == 0) || busy_in, 1'b0, (i == 1) || busy_in, i == 21);
            got = obs();
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL watchdog step %0d got %h exp %h", i, got, e);
            end
        end
    endtask

    task automatic test_boundary();
        logic [13:0] e, got;
        for (int i = 0; i <= 21; i++) begin
            if (i < 16)      e = pk(2'b01, 1'b0, 1'b0, 1'b0);
            else if (i < 20) e = pk(2'b10, 1'b0, 1'b0, 1'b0);
            else             e = pk(2'b00, 1'b0, 1'b0, 1'b0);
            sb.push_back(e);
            step(1'b1, i == 0, 1'b0, (i == 16) || (i == 20), i == 20);
            got = obs();
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL boundary step %0d got %h exp %h", i, got, e);
            end
        end
    endtask

    task automatic test_enable();
        logic [13:0] e, got;
        logic        en, st, pe;
        for (int i = 0; i <= 34; i++) begin
            en = !(((i >= 3) && (i <= 12)) || ((i >= 23) && (i <= 32)));
            st = (i == 0) || ((i >= 23) && (i <= 33));
            pe = !en || (i == 21) || (i == 22);
            if (i <= 20)      e = pk(2'b01, 1'b0, 1'b0, 1'b0);
            else if (i == 21) e = pk(2'b10, 1'b0, 1'b0, 1'b0);
            else if (i <= 32) begin
                if (i == 22) exp_iter = exp_iter + 8'd1;
                e = pk(2'b00, 1'b0, 1'b1, 1'b0);
            end else          e = pk(2'b00, 1'b0, 1'b0, 1'b0);
            sb.push_back(e);
            step(en, st, 1'b0, pe, 1'b0);
            got = obs();
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL enable step %0d got %h exp %h", i, got, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [13:0] e, got;
        for (int i = 0; i <= 3; i++) begin
            if (i == 0)      e = pk(2'b01, 1'b0, 1'b0, 1'b0);
            else if (i == 1) e = pk(2'b10, 1'b0, 1'b0, 1'b0);
            else             e = pk(2'b00, 1'b1, 1'b0, 1'b0);
            sb.push_back(e);
            step(1'b1, i == 0, 1'b1, (i == 1) || (i == 2), 1'b0);
            got = obs();
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL async_pre step %0d got %h exp %h", i, got, e);
            end
        end
        rst_i = 1'b0;
        exp_iter = 8'd0;
        sb.push_back(pk(2'b00, 1'b0, 1'b0, 1'b0));
        #1;
        got = obs();
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", got, e);
        end
        #2;
        rst_i = 1'b1;
        for (int i = 0; i <= 2; i++) begin
            e = (i == 1) ? pk(2'b01, 1'b0, 1'b0, 1'b0) : pk(2'b00, 1'b0, 1'b0, 1'b0);
            sb.push_back(e);
            step(1'b1, i == 1, 1'b0, 1'b0, i == 2);
            got = obs();
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL async_post step %0d got %h exp %h", i, got, e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [13:0] e, got;
        for (int s = 0; s < 256; s++) begin
            for (int j = 0; j < 4; j++) begin
                if (j == 0)      e = pk(2'b01, 1'b0, 1'b0, 1'b0);
                else if (j == 1) e = pk(2'b10, 1'b0, 1'b0, 1'b0);
                else if (j == 2) begin
                    exp_iter = exp_iter + 8'd1;
                    e = pk(2'b00, 1'b0, 1'b1, 1'b0);
                end else         e = pk(2'b00, 1'b0, 1'b0, 1'b0);
                sb.push_back(e);
                step(1'b1, j == 0, 1'b0, (j == 1) || (j == 2), 1'b0);
                got = obs();
                e = sb.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL wrap seq %0d step %0d got %h exp %h", s, j, got, e);
                end
            end
        end
        sb.push_back({6'd0, 8'd0});
        got = obs();
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL wrap_final got %h exp %h", got, e);
        end
    endtask

    initial begin
        rst_i      = 1'b0;
        en_i       = 1'b0;
        start_i    = 1'b0;
        bwd_en_i   = 1'b0;
        pass_end_i = 1'b0;
        abort_i    = 1'b0;
        test_reset();
        test_fwd_bwd();
        test_no_bwd();
        test_watchdog();
        test_boundary();
        test_enable();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pass_sequencer.md
# pass_sequencer

Parametrised pass controller that steps the datapath through NUM_FWD forward passes and an optional backward pass per training/inference sequence. Sits between top-level control (enable, start, abort) and the layer datapath, which reports end-of-pass strobes. Adds a per-pass watchdog, an abort path, a completion pulse and a sequence counter.

## Interface

Parameters:
- NUM_FWD, 2: number of forward passes per sequence (≥1).
- TIMEOUT, 255: max enabled cycles allowed per pass before error; 0 disables the watchdog.
- ITER_W, 8: width of the completed-sequence counter.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- en_i  in  1  global enable (top-level ena); when low, all state, counters and outputs hold and all inputs are ignored.
- start_i  in  1  level; begins a sequence when sampled in IDLE.
- bwd_en_i  in  1  mode; sampled with start_i; 1 = append backward pass.
- pass_end_i  in  1  single-cycle strobe from datapath: current pass finished.
- abort_i  in  1  returns to IDLE from any state.
- fwd_pass_o  out  NUM_FWD  one-hot; bit k high during forward pass k.
- b_pass_o  out  1  high during backward pass.
- busy_o  out  1  high in any FWD or BWD state.
- done_o  out  1  high for the single DONE state.
- err_o  out  1  high in ERR state.
- iter_o  out  ITER_W  count of sequences reaching DONE; wraps modulo 2^ITER_W.

## Operation

- States: IDLE, FWD(k) for k = 0..NUM_FWD-1 (state code plus index register), BWD, DONE, ERR.
- All outputs are Moore decodes of registered state; no combinational input-to-output paths.
- Reset: state IDLE, index 0, watchdog count 0, bwd mode latch 0, iter_o 0; all outputs 0.
- Transitions, evaluated only on enabled cycles, in priority order: abort_i > pass_end_i > watchdog expiry.
  - IDLE: start_i=1 -> FWD(0); latch bwd_en_i.
  - FWD(k), k < NUM_FWD-1: pass_end_i -> FWD(k+1).
  - FWD(NUM_FWD-1): pass_end_i -> BWD if latched mode = 1, else DONE.
  - BWD: pass_end_i -> DONE.
  - DONE: unconditionally -> IDLE next enabled cycle; iter_o increments on entry to DONE; start_i ignored in DONE.
  - ERR: held until abort_i; then -> IDLE. start_i and pass_end_i are ignored.
  - abort_i in IDLE: no effect. In FWD, BWD, DONE or ERR: -> IDLE. An abort in DONE still leaves iter_o incremented.
- Watchdog: cycle count is cleared on every entry into a FWD/BWD state and increments on each enabled cycle in that state. When the count equals TIMEOUT-1 and pass_end_i=0 and abort_i=0, the next state is ERR. A pass may therefore last at most TIMEOUT enabled cycles. pass_end_i on the expiry cycle wins.
- Count width: clog2(TIMEOUT+1). The counter saturates and never wraps. When TIMEOUT=0, the counter is held at 0 and ERR is unreachable.
- bwd_en_i changes mid-sequence have no effect.
- pass_end_i in IDLE, DONE or ERR is ignored.

## Timing

- start_i sampled high in IDLE at edge N: fwd_pass_o[0] and busy_o are high after edge N.
- pass_end_i high at edge N: the next pass output is asserted and the previous one deasserted after edge N. There is no gap cycle and no overlap.
- done_o is high for exactly one enabled cycle, or longer if en_i drops while in DONE.
- Minimum sequence with en_i held high: 1 + NUM_FWD (+1 if backward) passes. Each pass takes ≥1 cycle if pass_end_i is held high.
- Async reset mid-sequence: outputs clear immediately. Operation resumes from IDLE on the first edge after deassertion.

## Test plan

- NUM_FWD=2, TIMEOUT=16, bwd_en_i=1. Pulse start, then pass_end every 5 cycles -> fwd_pass_o = 01, then 10 (5 cycles each), then b_pass_o for 5 cycles, then done_o for 1 cycle, then IDLE; iter_o = 1.
- Same configuration with bwd_en_i=0, toggled to 1 mid-sequence -> FWD0, FWD1, DONE with no b_pass_o; iter_o increments.
- Hold pass_end_i low in FWD(1) -> err_o rises after exactly 16 cycles in FWD(1). start_i is then ignored. abort_i -> IDLE next cycle; iter_o unchanged.
- pass_end_i on the 16th cycle of a pass -> advances to the next pass, no ERR. abort_i together with pass_end_i -> IDLE.
- Drop en_i for 10 cycles inside FWD(0) and inside DONE while pulsing pass_end_i -> state, watchdog count and outputs frozen; strobes ignored. done_o is stretched for 10 cycles.
- Assert rst_i low mid-BWD -> all outputs 0 immediately and iter_o = 0. Run 256 full sequences -> iter_o wraps to 0.
